// File: rtl/bus_checker.sv
// Passive myBus checker: locks onto the counting DUT, predicts each data
// sample from the previous one, and keeps error, wrap and run statistics.
module bus_checker #(
  parameter int D_WIDTH = 8,
  parameter int CNT_W   = 16,
  parameter int RUN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] data,
  input  logic               clr,
  output logic               locked,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   wrap_cnt,
  output logic [RUN_W-1:0]   run_len,
  output logic [RUN_W-1:0]   max_run
);

  typedef enum logic [1:0] {
    WAIT_LOW,
    CHECK_ZERO,
    LOCKED
  } state_t;

  localparam logic [D_WIDTH-1:0] ONE_D = 1;
  localparam logic [CNT_W-1:0]   ONE_C = 1;
  localparam logic [RUN_W-1:0]   ONE_R = 1;

  state_t             state;
  state_t             state_nx;
  logic               prev_en;
  logic [D_WIDTH-1:0] prev_data;
  logic [D_WIDTH-1:0] expect_d;
  logic               miss;
  logic               wrap_hit;
  logic [RUN_W-1:0]   run_nx;

  // Case-equality so any X/Z on the bus is reported as a mismatch.
  always_comb begin
    state_nx = state;
    miss     = 1'b0;
    wrap_hit = 1'b0;
    expect_d = prev_en ? prev_data + ONE_D : '0;
    unique case (state)
      WAIT_LOW: begin
        if (!enable) state_nx = CHECK_ZERO;
      end
      CHECK_ZERO: begin
        if (data === '0) begin
          state_nx = LOCKED;
        end else begin
          miss     = 1'b1;
          state_nx = enable ? WAIT_LOW : CHECK_ZERO;
        end
      end
      LOCKED: begin
        miss     = (data !== expect_d);
        wrap_hit = !miss && prev_en && (&prev_data) && (data == '0);
      end
      default: state_nx = WAIT_LOW;
    endcase
  end

  always_comb begin
    run_nx = '0;
    if (enable) run_nx = (&run_len) ? run_len : run_len + ONE_R;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOW;
      prev_en   <= 1'b0;
      prev_data <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      wrap_cnt  <= '0;
      run_len   <= '0;
      max_run   <= '0;
    end else begin
      state     <= state_nx;
      prev_en   <= enable;
      prev_data <= data;
      locked    <= (state_nx == LOCKED);
      err       <= miss;
      if (clr) begin
        err_cnt  <= '0;
        wrap_cnt <= '0;
        run_len  <= '0;
        max_run  <= '0;
      end else begin
        if (miss && !(&err_cnt))      err_cnt  <= err_cnt + ONE_C;
        if (wrap_hit && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + ONE_C;
        run_len <= run_nx;
        max_run <= (run_nx > max_run) ? run_nx : max_run;
      end
    end
  end

endmodule

// File: tb/tb_bus_checker.sv
// Directed bench for bus_checker with a small counting-DUT model
// driving the bus beside it.
module tb_bus_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        frc;
  logic [7:0]  fval;
  logic [7:0]  cnt;
  logic [7:0]  data;
  logic        locked;
  logic        err;
  logic [15:0] err_cnt;
  logic [15:0] wrap_cnt;
  logic [7:0]  run_len;
  logic [7:0]  max_run;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)     cnt <= 8'd0;
    else if (en) cnt <= cnt + 8'd1;
    else         cnt <= 8'd0;
  end

  assign data = frc ? fval : cnt;

  bus_checker #(
    .D_WIDTH(8),
    .CNT_W  (16),
    .RUN_W  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (en),
    .data    (data),
    .clr     (clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .wrap_cnt(wrap_cnt),
    .run_len (run_len),
    .max_run (max_run)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
    chk({tag, "_wrap"}, 32'(wrap_cnt), 0);
    chk({tag, "_run"}, 32'(run_len), 0);
    chk({tag, "_max"}, 32'(max_run), 0);
  endtask

  task automatic lock_seq();
    en = 1'b0;
    step();
    chk("lock_e1", 32'(locked), 0);
    step();
    chk("lock_e2", 32'(locked), 1);
    chk("lock_e2_err", 32'(err), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; frc = 1'b0; fval = 8'd0;
    step();
    step();
    all_zero("reset");
    rst = 1'b0;

    // basic lock then data 0..4
    lock_seq();
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("basic_err", 32'(err), 0);
      chk("basic_run", 32'(run_len), i);
    end
    chk("basic_max", 32'(max_run), 5);
    chk("basic_errcnt", 32'(err_cnt), 0);

    // mismatch: 0x55 where 5 expected, then DUT 6 where 0x56 expected
    frc = 1'b1; fval = 8'h55;
    step();
    chk("mm1_err", 32'(err), 1);
    chk("mm1_cnt", 32'(err_cnt), 1);
    frc = 1'b0;
    step();
    chk("mm2_err", 32'(err), 1);
    chk("mm2_cnt", 32'(err_cnt), 2);
    step();
    chk("mm3_err", 32'(err), 0);
    chk("mm3_cnt", 32'(err_cnt), 2);
    chk("mm3_locked", 32'(locked), 1);
    chk("mm3_run", 32'(run_len), 8);

    // clear stats while dropping enable, then pattern 1,1,0,1
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_err", 32'(err), 0);
    chk("clr_errcnt", 32'(err_cnt), 0);
    chk("clr_max", 32'(max_run), 0);
    en = 1'b1;
    step();
    chk("drop_run1", 32'(run_len), 1);
    step();
    chk("drop_run2", 32'(run_len), 2);
    en = 1'b0;
    step();
    chk("drop_run0", 32'(run_len), 0);
    chk("drop_err", 32'(err), 0);
    en = 1'b1;
    step();
    chk("drop_run1b", 32'(run_len), 1);
    chk("drop_max", 32'(max_run), 2);
    chk("drop_errcnt", 32'(err_cnt), 0);

    // clear colliding with a mismatch
    frc = 1'b1; fval = 8'h99; clr = 1'b1;
    step();
    clr = 1'b0; frc = 1'b0;
    chk("coll_err", 32'(err), 1);
    chk("coll_errcnt", 32'(err_cnt), 0);
    chk("coll_locked", 32'(locked), 1);
    chk("coll_run", 32'(run_len), 0);
    step();
    chk("coll_next_err", 32'(err), 1);
    chk("coll_next_cnt", 32'(err_cnt), 1);
    step();
    chk("coll_ok_err", 32'(err), 0);
    frc = 1'b1; fval = 8'h11;
    step();
    frc = 1'b0;
    step();
    chk("pre_rst_cnt", 32'(err_cnt), 3);

    // reset mid-run
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    all_zero("midrst");
    lock_seq();

    // wrap: 300 enabled samples, data 255 -> 0 at sample 257
    en = 1'b1;
    repeat (256) step();
    chk("wrap_before", 32'(wrap_cnt), 0);
    step();
    chk("wrap_after", 32'(wrap_cnt), 1);
    repeat (43) step();
    chk("wrap_final", 32'(wrap_cnt), 1);
    chk("wrap_errcnt", 32'(err_cnt), 0);
    chk("wrap_run", 32'(run_len), 255);
    chk("wrap_max", 32'(max_run), 255);
    chk("wrap_locked", 32'(locked), 1);

    // nonzero data while waiting for the first zero
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0;
    frc = 1'b1; fval = 8'h07;
    step();
    chk("cz_wait_err", 32'(err), 0);
    step();
    chk("cz_err", 32'(err), 1);
    chk("cz_cnt", 32'(err_cnt), 1);
    chk("cz_locked", 32'(locked), 0);
    frc = 1'b0;
    step();
    chk("cz_relock", 32'(locked), 1);
    chk("cz_relock_err", 32'(err), 0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
